uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DATA_BITS, default 8, width of each queued byte and of o_tx_data.
REQ-002 Parameter ADDR_BITS, default 4, FIFO depth = 2**ADDR_BITS entries (16).
REQ-003 i_clk  in  1  system clock, all state updates on rising edge.
REQ-004 i_reset  in  1  asynchronous, active-high reset.
REQ-005 i_wr  in  1  push request, one entry per cycle while high.
REQ-006 i_wr_data  in  DATA_BITS  byte to push.
REQ-007 i_tx_done  in  1  one-cycle done pulse from the downstream UART transmitter.
REQ-008 i_tx_busy  in  1  downstream transmitter "transmitting" indicator.
REQ-009 o_tx_start  out  1  registered one-cycle start pulse to the transmitter.
REQ-010 o_tx_data  out  DATA_BITS  registered byte, stable from the o_tx_start cycle until the next pop.
REQ-011 o_full  out  1  high when count == 2**ADDR_BITS.
REQ-012 o_empty  out  1  high when count == 0.
REQ-013 o_count  out  ADDR_BITS+1  current occupancy, 0..2**ADDR_BITS.
REQ-014 o_overflow  out  1  sticky overflow flag (see Configuration).

Function
REQ-015 FIFO SHALL be circular: write/read pointers ADDR_BITS wide, wrap from 2**ADDR_BITS-1 to 0, occupancy in a separate ADDR_BITS+1 counter.
REQ-016 Push when not full SHALL store i_wr_data at write pointer and increment pointer and count at the same edge.
REQ-017 Push when full and no pop in that cycle SHALL be dropped; contents, pointers and count unchanged.
REQ-018 Push while full with pop in the same cycle SHALL be accepted; count unchanged.
REQ-019 Push and pop in the same cycle when not full SHALL leave count unchanged; push into an empty FIFO is never popped in the same cycle.
REQ-020 Drain FSM states: IDLE, START, WAIT_DONE.
REQ-021 IDLE -> START when !o_empty and !i_tx_busy; at that edge head entry is loaded into o_tx_data, read pointer increments, count decrements.
REQ-022 START lasts exactly one cycle with o_tx_start = 1, then -> WAIT_DONE unconditionally.
REQ-023 WAIT_DONE -> IDLE on the edge where i_tx_done = 1; otherwise hold; o_tx_start = 0.
REQ-024 i_tx_done in IDLE or START SHALL be ignored.
REQ-025 Latency: byte pushed into an empty FIFO with FSM in IDLE and i_tx_busy = 0 at edge k SHALL produce o_tx_start high in the cycle after edge k+1.
REQ-026 At most one o_tx_start per i_tx_done; back-to-back bytes separated by at least one IDLE cycle.

Reset
REQ-027 Reset SHALL asynchronously force: FSM IDLE, pointers 0, count 0, o_tx_start 0, o_tx_data 0, o_overflow 0, o_empty 1, o_full 0.
REQ-028 Reset mid-transmission SHALL discard all queued bytes; storage array need not be cleared.
REQ-029 After reset release, first pop SHALL occur no earlier than the second edge after the first push.

Configuration
REQ-030 Macro UART_TX_FIFO_OVERFLOW_EN defined: o_overflow set at the edge a push is dropped per REQ-017, held until reset.
REQ-031 Macro undefined: o_overflow tied to 0, no flag register synthesized; dropping behaviour unchanged.

Structure
REQ-032 Shared package uart_pkg SHALL hold the FSM state encoding (IDLE/START/WAIT_DONE, 2 bits) and default DATA_BITS/ADDR_BITS constants.
REQ-033 One sub-module, fifo_sync (storage, pointers, count, full/empty), instanced by uart_tx_fifo; drain FSM lives in the top.

Verification
REQ-034 Reset, push 0xA5 with i_tx_busy=0 -> o_tx_start one-cycle pulse 2 edges later with o_tx_data=0xA5, count back to 0.
REQ-035 Push 0x01,0x02,0x03 back-to-back, pulse i_tx_done 20 cycles after each start -> three starts in order 0x01,0x02,0x03, no start before each done.
REQ-036 i_tx_busy=1, push 17 bytes -> o_full after 16th, 17th dropped, o_count=16, o_overflow=1 only with UART_TX_FIFO_OVERFLOW_EN.
REQ-037 Full FIFO, push 0x7E on the cycle IDLE->START pops -> push accepted, count stays 16, 0x7E transmitted last.
REQ-038 Assert i_reset in WAIT_DONE with 5 queued bytes -> all outputs at reset values immediately, no further o_tx_start until a new push.
REQ-039 Push 40 bytes with periodic drains -> pointer wrap verified, output order matches input order, no loss while not full.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit FIFO slice: drain FSM state
// encoding and the default data/address widths.
package uart_pkg;

  localparam int DATA_BITS_DEF = 8;
  localparam int ADDR_BITS_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_START     = 2'b01,
    ST_WAIT_DONE = 2'b10
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo_fifo_sync.sv
// fifo_sync: circular synchronous FIFO with separate occupancy counter.
// A push while full is accepted only if a pop happens in the same cycle.
// The head entry is presented combinationally on o_head.
module fifo_sync
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF,
  parameter int ADDR_BITS = ADDR_BITS_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_push,
  input  logic                 i_pop,
  input  logic [DATA_BITS-1:0] i_data,
  output logic [DATA_BITS-1:0] o_head,
  output logic                 o_full,
  output logic                 o_empty,
  output logic [ADDR_BITS:0]   o_count
);

  localparam logic [ADDR_BITS:0]   DEPTH   = (ADDR_BITS+1)'(2**ADDR_BITS);
  localparam logic [ADDR_BITS:0]   CNT_ONE = (ADDR_BITS+1)'(1);
  localparam logic [ADDR_BITS-1:0] PTR_ONE = (ADDR_BITS)'(1);

  logic [DATA_BITS-1:0] mem_q [2**ADDR_BITS];
  logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_BITS:0]   count_q, count_d;
  logic                 pop_s;
  logic                 push_s;

  assign o_full  = (count_q == DEPTH);
  assign o_empty = (count_q == {(ADDR_BITS+1){1'b0}});
  assign o_count = count_q;
  assign o_head  = mem_q[rd_ptr_q];

  // A simultaneous pop frees the slot the full-FIFO push writes into.
  assign pop_s  = i_pop && !o_empty;
  assign push_s = i_push && (!o_full || pop_s);

  // Next-state for pointers (natural wrap at ADDR_BITS) and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; queued data is discarded on reset.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr_q <= {ADDR_BITS{1'b0}};
      rd_ptr_q <= {ADDR_BITS{1'b0}};
      count_q  <= {(ADDR_BITS+1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array write port; contents need no reset.
  always_ff @(posedge i_clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= i_data;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: transmit queue in front of a UART transmitter. Bytes are
// pushed with i_wr and drained one at a time by a three-state FSM that
// issues a registered o_tx_start pulse and waits for i_tx_done.
// Optional feature: define UART_TX_FIFO_OVERFLOW_EN for a sticky o_overflow
// flag on dropped pushes; otherwise o_overflow is tied low.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF,
  parameter int ADDR_BITS = ADDR_BITS_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_wr,
  input  logic [DATA_BITS-1:0] i_wr_data,
  input  logic                 i_tx_done,
  input  logic                 i_tx_busy,
  output logic                 o_tx_start,
  output logic [DATA_BITS-1:0] o_tx_data,
  output logic                 o_full,
  output logic                 o_empty,
  output logic [ADDR_BITS:0]   o_count,
  output logic                 o_overflow
);

  tx_state_e            state_q;
  logic                 tx_start_q;
  logic [DATA_BITS-1:0] tx_data_q;
  logic [DATA_BITS-1:0] head_s;
  logic                 full_s;
  logic                 empty_s;
  logic                 pop_s;

  // The head is taken only from IDLE, so a byte pushed into an empty FIFO
  // is visible to this check one edge after the push.
  assign pop_s = (state_q == ST_IDLE) && !empty_s && !i_tx_busy;

  fifo_sync #(
    .DATA_BITS (DATA_BITS),
    .ADDR_BITS (ADDR_BITS)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (i_wr),
    .i_pop   (pop_s),
    .i_data  (i_wr_data),
    .o_head  (head_s),
    .o_full  (full_s),
    .o_empty (empty_s),
    .o_count (o_count)
  );

  assign o_full     = full_s;
  assign o_empty    = empty_s;
  assign o_tx_start = tx_start_q;
  assign o_tx_data  = tx_data_q;

  // Drain FSM: IDLE pops the head, START pulses once, WAIT_DONE holds.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= {DATA_BITS{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pop_s) begin
            state_q    <= ST_START;
            tx_start_q <= 1'b1;
            tx_data_q  <= head_s;
          end else begin
            tx_start_q <= 1'b0;
          end
        end
        ST_START: begin
          state_q    <= ST_WAIT_DONE;
          tx_start_q <= 1'b0;
        end
        ST_WAIT_DONE: begin
          tx_start_q <= 1'b0;
          if (i_tx_done) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          tx_start_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef UART_TX_FIFO_OVERFLOW_EN
  logic overflow_q;

  // Sticky flag: set when a push is dropped, cleared only by reset.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      overflow_q <= 1'b0;
    end else if (i_wr && full_s && !pop_s) begin
      overflow_q <= 1'b1;
    end
  end

  assign o_overflow = overflow_q;
`else
  assign o_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: queue-based reference model
// compared against the DUT on every falling edge, directed scenarios
// with literal expectations, and a randomized push/drain phase.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
`ifdef UART_TX_FIFO_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_wr = 1'b0;
  logic [7:0] i_wr_data = 8'h00;
  logic       i_tx_done;
  logic       i_tx_busy;
  logic       o_tx_start;
  logic [7:0] o_tx_data;
  logic       o_full;
  logic       o_empty;
  logic [4:0] o_count;
  logic       o_overflow;

  uart_tx_fifo dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_wr       (i_wr),
    .i_wr_data  (i_wr_data),
    .i_tx_done  (i_tx_done),
    .i_tx_busy  (i_tx_busy),
    .o_tx_start (o_tx_start),
    .o_tx_data  (o_tx_data),
    .o_full     (o_full),
    .o_empty    (o_empty),
    .o_count    (o_count),
    .o_overflow (o_overflow)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transmitter emulation controls (written by main, read by emulator).
  bit force_busy = 1'b0;
  bit rand_busy  = 1'b0;
  bit rand_done  = 1'b0;
  int dly        = 3;
  int tmr        = 0;

  // Reference model state: a plain byte queue plus the transmit phase
  // (0 = ready for a byte, 1 = start cycle, 2 = waiting for done).
  logic [7:0] m_q[$];
  int         m_phase = 0;
  logic [7:0] m_data  = 8'h00;
  logic       m_ovf   = 1'b0;
  logic [7:0] tx_log[$];
  bit         check_en = 1'b0;

  // Inputs as seen at each rising edge.
  logic       s_rst = 1'b1;
  logic       s_wr, s_busy, s_done;
  logic [7:0] s_data;
  int         rst_cnt  = 0;
  int         rst_seen = 0;

  always @(posedge i_clk) begin
    s_rst  <= i_reset;
    s_wr   <= i_wr;
    s_data <= i_wr_data;
    s_busy <= i_tx_busy;
    s_done <= i_tx_done;
  end

  always @(posedge i_reset) rst_cnt <= rst_cnt + 1;

  task automatic model_clear();
    m_q.delete();
    m_phase = 0;
    m_data  = 8'h00;
    m_ovf   = 1'b0;
  endtask

  task automatic model_step(input logic wr, input logic [7:0] d, input logic busy, input logic done);
    bit pop;
    bit full;
    pop  = (m_phase == 0) && (m_q.size() != 0) && !busy;
    full = (m_q.size() == DEPTH);
    if (pop) m_data = m_q.pop_front();
    if (wr && (!full || pop)) m_q.push_back(d);
    else if (wr) m_ovf = OVF_EN;
    if (m_phase == 1) m_phase = 2;
    else if (m_phase == 2 && done) m_phase = 0;
    else if (pop) m_phase = 1;
  endtask

  // Compare process: advance the model for the last edge, then check.
  initial begin
    forever begin
      @(negedge i_clk);
      if (!s_rst) model_step(s_wr, s_data, s_busy, s_done);
      if (i_reset || rst_cnt != rst_seen) model_clear();
      rst_seen = rst_cnt;
      if (check_en) begin
        chk("tx_start", o_tx_start, m_phase == 1);
        chk("tx_data",  o_tx_data,  m_data);
        chk("count",    o_count,    m_q.size());
        chk("empty",    o_empty,    m_q.size() == 0);
        chk("full",     o_full,     m_q.size() == DEPTH);
        chk("overflow", o_overflow, m_ovf);
      end
      if (o_tx_start) tx_log.push_back(o_tx_data);
    end
  end

  // Downstream transmitter emulation: done pulse dly cycles after start.
  initial begin
    i_tx_done = 1'b0;
    i_tx_busy = 1'b0;
    forever begin
      @(negedge i_clk);
      #1;
      i_tx_done = 1'b0;
      if (i_reset) begin
        tmr = 0;
      end else begin
        if (tmr > 0) begin
          tmr--;
          if (tmr == 0) i_tx_done = 1'b1;
        end
        if (o_tx_start) tmr = dly;
        if (rand_done && tmr == 0 && $urandom_range(0, 15) == 0) i_tx_done = 1'b1;
      end
      i_tx_busy = force_busy || (tmr > 0) || (rand_busy && $urandom_range(0, 3) == 0);
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge i_clk);
  endtask

  task automatic push(input logic [7:0] d);
    i_wr      = 1'b1;
    i_wr_data = d;
    @(negedge i_clk);
    i_wr      = 1'b0;
  endtask

  int base;
  int n_rand;
  int wr_pct;

  initial begin
    // Reset state
    idle(3);
    chk("rst_count", o_count, 0);
    chk("rst_empty", o_empty, 1);
    chk("rst_full",  o_full,  0);
    chk("rst_start", o_tx_start, 0);
    chk("rst_data",  o_tx_data, 0);
    chk("rst_ovf",   o_overflow, 0);
    i_reset  = 1'b0;
    check_en = 1'b1;
    idle(2);

    // Single byte: start pulse two edges after the push
    push(8'hA5);
    chk("a5_count_mid", o_count, 1);
    @(negedge i_clk);
    chk("a5_start", o_tx_start, 1);
    chk("a5_data",  o_tx_data, 8'hA5);
    chk("a5_count", o_count, 0);
    @(negedge i_clk);
    chk("a5_start_end", o_tx_start, 0);
    idle(10);

    // Three bytes, done 20 cycles after each start
    dly  = 20;
    base = tx_log.size();
    push(8'h01);
    push(8'h02);
    push(8'h03);
    idle(120);
    chk("seq_n",  tx_log.size() - base, 3);
    chk("seq_b0", tx_log[base],     8'h01);
    chk("seq_b1", tx_log[base + 1], 8'h02);
    chk("seq_b2", tx_log[base + 2], 8'h03);

    // Fill while busy: 17th push dropped
    dly        = 3;
    force_busy = 1'b1;
    idle(2);
    for (int i = 0; i < 17; i++) begin
      push(8'h10 + 8'(i));
      if (i == 15) chk("full_after16", o_full, 1);
    end
    chk("fill_count", o_count, 16);
    chk("fill_full",  o_full, 1);
    chk("fill_ovf",   o_overflow, OVF_EN);

    // Push on the pop cycle while full
    base       = tx_log.size();
    force_busy = 1'b0;
    push(8'h7E);
    chk("fp_count", o_count, 16);
    chk("fp_start", o_tx_start, 1);
    chk("fp_data",  o_tx_data, 8'h10);
    idle(200);
    chk("fp_n",     tx_log.size() - base, 17);
    chk("fp_last",  tx_log[tx_log.size() - 1], 8'h7E);
    chk("fp_15",    tx_log[base + 15], 8'h1F);
    chk("fp_ovf_hold", o_overflow, OVF_EN);

    // Reset while waiting for done with 5 queued
    force_busy = 1'b1;
    idle(2);
    for (int i = 0; i < 6; i++) push(8'h40 + 8'(i));
    dly        = 30;
    force_busy = 1'b0;
    idle(4);
    chk("pre_rst_count", o_count, 5);
    #2;
    i_reset = 1'b1;
    #1;
    chk("mid_rst_count", o_count, 0);
    chk("mid_rst_empty", o_empty, 1);
    chk("mid_rst_full",  o_full, 0);
    chk("mid_rst_start", o_tx_start, 0);
    chk("mid_rst_data",  o_tx_data, 0);
    chk("mid_rst_ovf",   o_overflow, 0);
    @(negedge i_clk);
    i_reset = 1'b0;
    base    = tx_log.size();
    idle(40);
    chk("no_start_after_rst", tx_log.size() - base, 0);

    // Randomized pushes with periodic drains
    dly       = 2;
    rand_busy = 1'b1;
    rand_done = 1'b1;
    base      = tx_log.size();
    wr_pct    = 80;
    for (int c = 0; c < 800; c++) begin
      if (c % 100 == 0) wr_pct = (wr_pct == 80) ? 15 : 80;
      dly       = $urandom_range(1, 6);
      i_wr      = ($urandom_range(0, 99) < wr_pct);
      i_wr_data = 8'($urandom);
      @(negedge i_clk);
    end
    i_wr      = 1'b0;
    rand_busy = 1'b0;
    rand_done = 1'b0;
    dly       = 2;
    idle(300);
    n_rand = tx_log.size() - base;
    chk("rand_starts_ge40", n_rand >= 40, 1);
    chk("rand_drained", o_empty, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
